// File: rtl/avr_cpu_mul_seq.sv
// ---------------------------------------------------------------------------
// avr_cpu_mul_seq
//   Multi-cycle radix-2 shift-add multiplier for the AVR execute stage.
//   Handles MUL, MULS, MULSU, FMUL, FMULS and FMULSU (opcodes 6/7 act as MUL)
//   and produces a 2*WIDTH-bit product plus SREG with C and Z updated.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-high reset, clears all state
//   start       request, accepted only while busy is low
//   opcode      0 MUL, 1 MULS, 2 MULSU, 3 FMUL, 4 FMULS, 5 FMULSU
//   d_in        multiplicand (Rd)
//   r_in        multiplier (Rr)
//   status_in   SREG before the instruction
//   busy        operation in progress
//   done        one-cycle pulse when product/status_out are updated
//   product     2*WIDTH-bit result, held until the next completion
//   status_out  status_in with bit0 (C) and bit1 (Z) replaced
// ---------------------------------------------------------------------------
module avr_cpu_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         opcode,
    input  logic [WIDTH-1:0]   d_in,
    input  logic [WIDTH-1:0]   r_in,
    input  logic [7:0]         status_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [7:0]         status_out
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } state_t;

    state_t           state_q;
    logic [2:0]       opcode_q;
    logic [7:0]       sreg_q;
    logic             sign_q;
    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;
    logic             done_q;
    logic [PW-1:0]    product_q;
    logic [7:0]       status_q;

    // Operand decode at capture time
    logic             d_signed;
    logic             r_signed;
    logic             d_neg;
    logic             r_neg;
    logic [WIDTH-1:0] d_mag;
    logic [WIDTH-1:0] r_mag;

    // Datapath next values
    logic             frac;
    logic [PW-1:0]    acc_d;
    logic [PW-1:0]    raw_d;
    logic [PW-1:0]    product_d;
    logic [7:0]       status_d;

    always_comb begin
        d_signed = opcode inside {3'd1, 3'd2, 3'd4, 3'd5};
        r_signed = opcode inside {3'd1, 3'd4};
        d_neg    = d_signed & d_in[WIDTH-1];
        r_neg    = r_signed & r_in[WIDTH-1];
        // Two's-complement negate; the most negative value maps onto 2^(WIDTH-1).
        d_mag    = d_neg ? -d_in : d_in;
        r_mag    = r_neg ? -r_in : r_in;
    end

    always_comb begin
        acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        frac      = opcode_q inside {3'd3, 3'd4, 3'd5};
        raw_d     = sign_q ? -acc_q : acc_q;
        // C comes from the unshifted result, Z from the final (shifted) product.
        product_d = frac ? {raw_d[PW-2:0], 1'b0} : raw_d;
        status_d  = {sreg_q[7:2], (product_d == '0), raw_d[PW-1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            opcode_q  <= '0;
            sreg_q    <= '0;
            sign_q    <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            product_q <= '0;
            status_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        opcode_q <= opcode;
                        sreg_q   <= status_in;
                        sign_q   <= d_neg ^ r_neg;
                        mcand_q  <= PW'(d_mag);
                        mplier_q <= r_mag;
                        acc_q    <= '0;
                        cnt_q    <= CW'(WIDTH - 1);
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    if (cnt_q == '0) begin
                        state_q <= ST_FIX;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_FIX: begin
                    product_q <= product_d;
                    status_q  <= status_d;
                    done_q    <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign product    = product_q;
    assign status_out = status_q;

endmodule

// File: tb/tb_avr_cpu_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_avr_cpu_mul_seq
//   Self-checking bench for avr_cpu_mul_seq (WIDTH=8 and WIDTH=16 instances).
//   Expected results come from plain signed/unsigned integer multiplication.
// ---------------------------------------------------------------------------
module tb_avr_cpu_mul_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic [2:0]  opcode;
    logic [7:0]  d_in;
    logic [7:0]  r_in;
    logic [7:0]  status_in;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [7:0]  status_out;

    logic        start16;
    logic [2:0]  opcode16;
    logic [15:0] d16;
    logic [15:0] r16;
    logic [7:0]  st16;
    logic        busy16;
    logic        done16;
    logic [31:0] product16;
    logic [7:0]  status16;

    int vectors     = 0;
    int miscompares = 0;

    avr_cpu_mul_seq #(.WIDTH(8)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .opcode     (opcode),
        .d_in       (d_in),
        .r_in       (r_in),
        .status_in  (status_in),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .status_out (status_out)
    );

    avr_cpu_mul_seq #(.WIDTH(16)) u_dut16 (
        .clk        (clk),
        .reset      (reset),
        .start      (start16),
        .opcode     (opcode16),
        .d_in       (d16),
        .r_in       (r16),
        .status_in  (st16),
        .busy       (busy16),
        .done       (done16),
        .product    (product16),
        .status_out (status16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {status_out, product} from integer arithmetic.
    function automatic logic [23:0] model(input logic [2:0] op, input logic [7:0] d,
                                          input logic [7:0] r, input logic [7:0] st);
        int          dv;
        int          rv;
        int          p;
        logic [15:0] raw;
        logic [15:0] prod;
        if (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5) dv = int'($signed(d));
        else                                                         dv = int'({24'd0, d});
        if (op == 3'd1 || op == 3'd4) rv = int'($signed(r));
        else                          rv = int'({24'd0, r});
        p   = dv * rv;
        raw = p[15:0];
        if (op >= 3'd3 && op <= 3'd5) prod = {raw[14:0], 1'b0};
        else                          prod = raw;
        return {st[7:2], (prod == 16'h0000), raw[15], prod};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [2:0] op, input logic [7:0] d, input logic [7:0] r,
                          input logic [7:0] st);
        opcode    = op;
        d_in      = d;
        r_in      = r;
        status_in = st;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [2:0] op, input logic [7:0] d,
                             input logic [7:0] r, input logic [7:0] st,
                             input logic [15:0] ep, input logic [7:0] es);
        int lat;
        launch(op, d, r, st);
        check({tag, ".busy"}, 64'(busy), 64'(1));
        wait_done(lat);
        check({tag, ".latency"}, 64'(lat), 64'(9));
        check({tag, ".busy_in_done"}, 64'(busy), 64'(0));
        check({tag, ".product"}, 64'(product), 64'(ep));
        check({tag, ".status"}, 64'(status_out), 64'(es));
        tick();
        check({tag, ".done_fall"}, 64'(done), 64'(0));
    endtask

    initial begin
        logic [23:0] m;
        logic [23:0] m2;
        logic [2:0]  rop;
        logic [7:0]  rd;
        logic [7:0]  rr;
        logic [7:0]  rs;
        int          lat;
        int          ndone;
        int          done_at;
        logic [15:0] held;

        reset    = 1'b1;
        start    = 1'b1;
        opcode   = 3'd0;
        d_in     = 8'h03;
        r_in     = 8'h05;
        status_in = 8'h3C;
        start16  = 1'b0;
        opcode16 = 3'd0;
        d16      = '0;
        r16      = '0;
        st16     = '0;

        // Reset held with start asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst.busy", 64'(busy), 64'(0));
            check("rst.done", 64'(done), 64'(0));
            check("rst.product", 64'(product), 64'(0));
            check("rst.status", 64'(status_out), 64'(0));
        end
        reset = 1'b0;
        check("rel.busy_before_edge", 64'(busy), 64'(0));
        tick();
        check("rel.busy_after_edge", 64'(busy), 64'(1));
        start = 1'b0;
        wait_done(lat);
        check("rel.latency", 64'(lat), 64'(9));
        check("rel.product", 64'(product), 64'(16'h000F));
        check("rel.status", 64'(status_out), 64'(8'h3C));
        tick();

        // Directed vectors
        run_check("mul_ff_ff",   3'd0, 8'hFF, 8'hFF, 8'h00, 16'hFE01, 8'h01);
        run_check("mul_00_37",   3'd0, 8'h00, 8'h37, 8'hC0, 16'h0000, 8'hC2);
        run_check("muls_80_80",  3'd1, 8'h80, 8'h80, 8'h00, 16'h4000, 8'h00);
        run_check("muls_ff_01",  3'd1, 8'hFF, 8'h01, 8'h00, 16'hFFFF, 8'h01);
        run_check("mulsu_ff_ff", 3'd2, 8'hFF, 8'hFF, 8'h00, 16'hFF01, 8'h01);
        run_check("fmul_80_80",  3'd3, 8'h80, 8'h80, 8'h00, 16'h8000, 8'h00);
        run_check("fmul_c0_c0",  3'd3, 8'hC0, 8'hC0, 8'h00, 16'h2000, 8'h01);
        run_check("fmuls_80_80", 3'd4, 8'h80, 8'h80, 8'h00, 16'h8000, 8'h00);

        // Randomised operations against the integer model
        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            rd  = 8'($urandom);
            rr  = 8'($urandom);
            rs  = 8'($urandom);
            if (n % 8 == 0) rd = 8'h80;
            if (n % 8 == 1) rr = 8'h80;
            if (n % 8 == 2) rr = 8'h00;
            m = model(rop, rd, rr, rs);
            run_check("rand", rop, rd, rr, rs, m[15:0], m[23:16]);
        end

        // Input changes and a second start during a running operation
        m = model(3'd0, 8'h12, 8'h34, 8'h00);
        launch(3'd0, 8'h12, 8'h34, 8'h00);
        tick();
        tick();
        d_in   = 8'hFF;
        r_in   = 8'hFF;
        tick();
        opcode = 3'd1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        ndone   = 0;
        done_at = -1;
        for (int i = 5; i <= 24; i++) begin
            tick();
            if (done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = i;
                    check("busy_start.product", 64'(product), 64'(m[15:0]));
                end
            end
        end
        check("busy_start.done_count", 64'(ndone), 64'(1));
        check("busy_start.done_edge", 64'(done_at), 64'(9));

        // Back-to-back: start in the done cycle, old product held until new done
        run_check("b2b_first", 3'd0, 8'h0B, 8'h0D, 8'h00, 16'h008F, 8'h00);
        launch(3'd0, 8'h21, 8'h07, 8'h00);
        wait_done(lat);
        m = model(3'd0, 8'h21, 8'h07, 8'h00);
        launch(3'd1, 8'hF0, 8'h07, 8'h80);
        m2  = model(3'd1, 8'hF0, 8'h07, 8'h80);
        held = m[15:0];
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            check("b2b.held", 64'(product), 64'(held));
            tick();
        end
        check("b2b.latency", 64'(lat), 64'(10));
        check("b2b.product", 64'(product), 64'(m2[15:0]));
        check("b2b.status", 64'(status_out), 64'(m2[23:16]));
        tick();

        // Reset in the middle of RUN
        launch(3'd0, 8'hAB, 8'hCD, 8'hFF);
        tick();
        tick();
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("midrst.busy", 64'(busy), 64'(0));
        check("midrst.done", 64'(done), 64'(0));
        check("midrst.product", 64'(product), 64'(0));
        check("midrst.status", 64'(status_out), 64'(0));
        tick();
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) ndone++;
        end
        check("midrst.no_done", 64'(ndone), 64'(0));
        run_check("after_rst", 3'd0, 8'h03, 8'h05, 8'h00, 16'h000F, 8'h00);

        // WIDTH=16 instance
        opcode16 = 3'd1;
        d16      = 16'h8000;
        r16      = 16'h8000;
        st16     = 8'hA5;
        start16  = 1'b1;
        tick();
        start16  = 1'b0;
        check("w16.busy", 64'(busy16), 64'(1));
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done16) begin
                lat = i;
                break;
            end
        end
        check("w16.latency", 64'(lat), 64'(17));
        check("w16.product", 64'(product16), 64'(32'h40000000));
        check("w16.status", 64'(status16), 64'(8'hA4));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
